// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types for the program loader.
//   state_t  - loader FSM states
//   ERR_*    - err_code encodings reported to the host side
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/prog_loader_sync.sv
// sync_edge: N-stage synchroniser for an asynchronous level, with
// registered single-cycle rise/fall pulses derived from the synced level.
// Ports:
//   clk, rst_n - clock, async active-low reset (clears the chain)
//   din        - asynchronous input level
//   level      - synchronised level (last chain stage)
//   rise, fall - one-cycle pulses, one cycle after the synced level changes
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchroniser chain plus edge-detect register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign level = chain[STAGES-1];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image (length, data, checksum)
// from a host over a byte-wide 4-phase strobe/ack handshake and writes it
// into the core's unified memory, holding the core in reset until a valid
// image has landed.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   load_req            - async host level, rising edge starts a load
//   host_stb, host_data - async 4-phase strobe and its data byte
//   host_ack            - handshake acknowledge
//   mem_we/addr/wdata   - one-cycle write port into core memory
//   cpu_hold            - keeps the core in reset while 1
//   load_done, load_err - load outcome flags
//   err_code            - 00 none, 01 length, 10 checksum, 11 timeout/abort
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              host_stb,
  input  logic [7:0]        host_data,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  logic stb_rise, stb_fall, unused_stb_lvl;
  logic req_rise, req_lvl, unused_req_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (host_stb),
    .level (unused_stb_lvl),
    .rise  (stb_rise),
    .fall  (stb_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (load_req),
    .level (req_lvl),
    .rise  (req_rise),
    .fall  (unused_req_fall)
  );

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               ack_d, we_d, hold_d, done_d, lerr_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [7:0]         wdata_d;
  logic [1:0]         code_d;

  logic               accept;
  logic [8:0]         len_ext;
  logic               len_ok;
  logic [7:0]         sum_next;
  logic [LEN_W-1:0]   cnt_next;

  // A strobe rise while ack is still high is outside the protocol: drop it
  assign accept   = stb_rise & ~host_ack;
  assign len_ext  = {1'b0, host_data};
  assign len_ok   = (len_ext != 9'd0) && (len_ext <= 9'(DEPTH));
  assign sum_next = sum_q + host_data;
  assign cnt_next = cnt_q + LEN_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    timer_d = timer_q;
    ack_d   = host_ack;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    hold_d  = cpu_hold;
    done_d  = load_done;
    lerr_d  = load_err;
    code_d  = err_code;

    // Ack release follows the strobe in every state so the host never stalls
    if (stb_fall) ack_d = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (req_rise) begin
          state_d = LEN;
          done_d  = 1'b0;
          lerr_d  = 1'b0;
          code_d  = ERR_NONE;
          hold_d  = 1'b1;
          cnt_d   = '0;
          sum_d   = '0;
          timer_d = '0;
        end
      end

      LEN, DATA, CSUM: begin
        // Abort outranks a byte arriving in the same cycle
        if (!req_lvl) begin
          state_d = ERROR;
          lerr_d  = 1'b1;
          hold_d  = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else if (accept) begin
          ack_d   = 1'b1;
          timer_d = '0;
          if (state_q == LEN) begin
            if (len_ok) begin
              len_d   = LEN_W'(host_data);
              sum_d   = '0;
              cnt_d   = '0;
              state_d = DATA;
            end else begin
              state_d = ERROR;
              lerr_d  = 1'b1;
              hold_d  = 1'b1;
              code_d  = ERR_LEN;
            end
          end else if (state_q == DATA) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = host_data;
            sum_d   = sum_next;
            cnt_d   = cnt_next;
            if (cnt_next == len_q) state_d = CSUM;
          end else begin
            if (sum_next == 8'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = ERROR;
              lerr_d  = 1'b1;
              hold_d  = 1'b1;
              code_d  = ERR_CSUM;
            end
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
          lerr_d  = 1'b1;
          hold_d  = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      timer_q   <= '0;
      host_ack  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      timer_q   <= timer_d;
      host_ack  <= ack_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      cpu_hold  <= hold_d;
      load_done <= done_d;
      load_err  <= lerr_d;
      err_code  <= code_d;
    end
  end

endmodule
